instruction_buffer: RTL
=======================

// Module: instruction_buffer
// PURPOSE
// Per-warp instruction FIFOs between the decoder and the dispatch/issue stage.
// Uses credits so the fetcher never fetches more instructions for a warp than the buffer can hold.
// Drives the fetcher's per-warp space-available vector.
// Reserves a slot when the I-cache accepts a fetch; fills that slot when the decoder returns
// the decoded instruction.
// PARAMETERS
// PcWidth   32  program counter width
// NumWarps  8   warps per compute unit
// WarpWidth 32  threads per warp (active-mask width)
// InstWidth 32  decoded instruction payload width
// IbDepth   2   entries per warp FIFO, >=1, need not be a power of two
// PORTS
// clk_i                 in   1                     clock; all state updates on rising edge
// rst_i                 in   1                     synchronous reset, active-high
// ib_space_available_o  out  NumWarps              warp w may be fetched (credit free)
// fe_handshake_i        in   1                     fetch accepted by I-cache (fe_valid & ic_ready)
// fe_warp_id_i          in   clog2(NumWarps)       warp of the accepted fetch
// dec_valid_i           in   1                     decoder writes one decoded instruction
// dec_warp_id_i         in   clog2(NumWarps)       target warp
// dec_pc_i              in   PcWidth               PC of decoded instruction
// dec_act_mask_i        in   WarpWidth             active mask of instruction
// dec_inst_i            in   InstWidth             decoded instruction payload
// ib_valid_o            out  NumWarps              head entry of warp w valid
// ib_pc_o               out  NumWarps*PcWidth      head PC per warp
// ib_act_mask_o         out  NumWarps*WarpWidth    head active mask per warp
// ib_inst_o             out  NumWarps*InstWidth    head instruction per warp
// disp_pop_i            out  NumWarps              (input) pop head of warp w; any combination allowed
// BEHAVIOUR
// - State per warp:
//   - used[w], range 0..IbDepth: entries holding data.
//   - resv[w], range 0..IbDepth: reserved, unfilled slots.
//   - rd_ptr/wr_ptr: clog2(IbDepth) bits; max(1,...) when IbDepth==1.
//   - Storage: IbDepth entries of {pc, act_mask, inst}.
// - Reset (rst_i=1 at edge): used=resv=0 and pointers=0 for all warps.
//   - After reset: ib_valid_o=0, ib_space_available_o=all ones.
//   - Storage is not reset; the data outputs are don't-care while ib_valid_o[w]=0.
//   - Reset mid-operation discards all entries and reservations.
// - ib_space_available_o[w] = (used[w]+resv[w]) < IbDepth.
//   - Combinational from registers only; no combinational path from any input.
// - ib_valid_o[w] = (used[w] != 0). Head outputs come straight from storage[rd_ptr].
// - Fetch: fe_handshake_i with warp f increments resv[f] at the next edge.
// - Write: dec_valid_i with warp d stores the entry at wr_ptr[d].
//   - wr_ptr[d] advances; used[d]+1, resv[d]-1.
//   - There is no ready signal; space is guaranteed by the reservation.
// - Pop: disp_pop_i[w] with used[w]!=0 advances rd_ptr[w]; used[w]-1.
//   - Popping an empty warp is ignored and flagged by an assertion.
// - Pointers wrap from IbDepth-1 to 0.
// - Latency: a written entry is visible on ib_valid_o one cycle later. No write-to-head bypass.
//   - A write and a pop of the same warp in one cycle: net used unchanged; a pop of an empty
//     warp is still ignored even if a write lands that cycle.
// - Simultaneous fetch, write and pop on the same warp apply independently; the counters take
//   the net sum, e.g. resv +1-1=0, used +1-1=0.
// - Fetch and write may target different warps in the same cycle.
// - Assertions (simulation only):
//   - No fetch handshake while ib_space_available_o[f]=0.
//   - No dec_valid_i while resv[d]=0.
//   - No pop while used[w]=0.
//   - used+resv <= IbDepth at all times.
// TESTING
// - Reset, then idle: ib_space_available_o=8'hFF, ib_valid_o=8'h00 for 10 cycles.
// - Warp 3, IbDepth=2:
//   - Two fetch handshakes -> space[3]=0 from the 2nd cycle after the first handshake.
//   - Write pc=0x100, then 0x104 -> ib_valid_o[3]=1, head pc 0x100.
//   - Pop -> head 0x104. Pop -> valid=0 and space[3]=1 the cycle after the pop.
// - Same-cycle write and pop on warp 1 with used=1 -> used stays 1; the new entry becomes head
//   next cycle, with correct act_mask and inst.
// - Pointer wrap: 5 fetch/write/pop round trips on warp 7 with pc 0x0,0x4,...,0x10 ->
//   heads emerge in order with no loss or duplicates.
// - Reset asserted while warps 0 and 5 hold 1 entry and 1 reservation -> next cycle all valid=0
//   and all space=1; a late decoder write is not issued by the bench.
// - Random: fetch/write/pop on 8 warps for 10k cycles against a scoreboard -> per-warp order
//   preserved and no assertion fires.

Source files
------------

// File: rtl/instruction_buffer_if.sv
// Decoder/fetcher/dispatch side bundle of the per-warp instruction buffer.
// The master modport is the surrounding pipeline; the slave modport is the buffer itself.
interface instruction_buffer_if #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int InstWidth = 32
);
    localparam int WidW = (NumWarps > 1) ? $clog2(NumWarps) : 1;

    logic [NumWarps-1:0]           ib_space_available_o;
    logic                          fe_handshake_i;
    logic [WidW-1:0]               fe_warp_id_i;
    logic                          dec_valid_i;
    logic [WidW-1:0]               dec_warp_id_i;
    logic [PcWidth-1:0]            dec_pc_i;
    logic [WarpWidth-1:0]          dec_act_mask_i;
    logic [InstWidth-1:0]          dec_inst_i;
    logic [NumWarps-1:0]           ib_valid_o;
    logic [NumWarps*PcWidth-1:0]   ib_pc_o;
    logic [NumWarps*WarpWidth-1:0] ib_act_mask_o;
    logic [NumWarps*InstWidth-1:0] ib_inst_o;
    logic [NumWarps-1:0]           disp_pop_i;

    modport master (
        input  ib_space_available_o, ib_valid_o, ib_pc_o, ib_act_mask_o, ib_inst_o,
        output fe_handshake_i, fe_warp_id_i, dec_valid_i, dec_warp_id_i,
               dec_pc_i, dec_act_mask_i, dec_inst_i, disp_pop_i
    );

    modport slave (
        output ib_space_available_o, ib_valid_o, ib_pc_o, ib_act_mask_o, ib_inst_o,
        input  fe_handshake_i, fe_warp_id_i, dec_valid_i, dec_warp_id_i,
               dec_pc_i, dec_act_mask_i, dec_inst_i, disp_pop_i
    );
endinterface

// File: rtl/instruction_buffer.sv
// Per-warp instruction FIFOs with fetch credits: a slot is reserved on I-cache accept
// and filled when the decoder delivers the instruction.
module instruction_buffer_chk #(
    parameter int NumWarps = 8,
    parameter int WidW     = 3
) (
    input logic                clk_i,
    input logic                rst_i,
    input logic                fe_handshake_i,
    input logic [WidW-1:0]     fe_warp_id_i,
    input logic                dec_valid_i,
    input logic [WidW-1:0]     dec_warp_id_i,
    input logic [NumWarps-1:0] disp_pop_i,
    input logic [NumWarps-1:0] space_i,
    input logic [NumWarps-1:0] resv_nz_i,
    input logic [NumWarps-1:0] used_nz_i,
    input logic [NumWarps-1:0] over_i
);
    // Protocol and invariant checks, sampled on every rising edge outside reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_fetch_credit: assert (!(fe_handshake_i && !space_i[fe_warp_id_i]));
            a_write_resv:   assert (!(dec_valid_i && !resv_nz_i[dec_warp_id_i]));
            a_pop_nonempty: assert ((disp_pop_i & ~used_nz_i) == {NumWarps{1'b0}});
            a_capacity:     assert (over_i == {NumWarps{1'b0}});
        end
    end
endmodule

module instruction_buffer #(
    parameter int PcWidth   = 32,
    parameter int NumWarps  = 8,
    parameter int WarpWidth = 32,
    parameter int InstWidth = 32,
    parameter int IbDepth   = 2
) (
    input logic                  clk_i,
    input logic                  rst_i,
    instruction_buffer_if.slave  ib
);
    localparam int WidW = (NumWarps > 1) ? $clog2(NumWarps) : 1;
    localparam int PtrW = (IbDepth > 1) ? $clog2(IbDepth) : 1;
    localparam int CntW = $clog2(IbDepth + 1);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(IbDepth - 1);
    localparam logic [CntW:0]   CntDepth = (CntW + 1)'(IbDepth);

    logic [CntW-1:0]      r_used   [NumWarps];
    logic [CntW-1:0]      r_resv   [NumWarps];
    logic [PtrW-1:0]      r_rd_ptr [NumWarps];
    logic [PtrW-1:0]      r_wr_ptr [NumWarps];
    logic [PcWidth-1:0]   r_pc     [NumWarps][IbDepth];
    logic [WarpWidth-1:0] r_mask   [NumWarps][IbDepth];
    logic [InstWidth-1:0] r_inst   [NumWarps][IbDepth];

    logic [NumWarps-1:0]  w_fetch;
    logic [NumWarps-1:0]  w_write;
    logic [NumWarps-1:0]  w_pop;
    logic [NumWarps-1:0]  w_space;
    logic [NumWarps-1:0]  w_resv_nz;
    logic [NumWarps-1:0]  w_used_nz;
    logic [NumWarps-1:0]  w_over;
    logic [CntW-1:0]      w_used_nxt [NumWarps];
    logic [CntW-1:0]      w_resv_nxt [NumWarps];
    logic [CntW:0]        w_total    [NumWarps];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? PtrW'(0) : p + PtrW'(1);
    endfunction

    // Per-warp event decode and next-count arithmetic; pops of empty warps are dropped.
    always_comb begin
        for (int w = 0; w < NumWarps; w++) begin
            w_fetch[w]    = ib.fe_handshake_i && (ib.fe_warp_id_i == WidW'(w));
            w_write[w]    = ib.dec_valid_i && (ib.dec_warp_id_i == WidW'(w));
            w_used_nz[w]  = (r_used[w] != CntW'(0));
            w_resv_nz[w]  = (r_resv[w] != CntW'(0));
            w_pop[w]      = ib.disp_pop_i[w] && w_used_nz[w];
            w_total[w]    = {1'b0, r_used[w]} + {1'b0, r_resv[w]};
            w_space[w]    = (w_total[w] < CntDepth);
            w_over[w]     = (w_total[w] > CntDepth);
            w_used_nxt[w] = (r_used[w] + CntW'(w_write[w])) - CntW'(w_pop[w]);
            w_resv_nxt[w] = (r_resv[w] + CntW'(w_fetch[w])) - CntW'(w_write[w]);
        end
    end

    // Counters and pointers; reset discards all entries and outstanding reservations.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWarps; w++) begin
                r_used[w]   <= CntW'(0);
                r_resv[w]   <= CntW'(0);
                r_rd_ptr[w] <= PtrW'(0);
                r_wr_ptr[w] <= PtrW'(0);
            end
        end else begin
            for (int w = 0; w < NumWarps; w++) begin
                r_used[w]   <= w_used_nxt[w];
                r_resv[w]   <= w_resv_nxt[w];
                r_rd_ptr[w] <= w_pop[w]   ? ptr_inc(r_rd_ptr[w]) : r_rd_ptr[w];
                r_wr_ptr[w] <= w_write[w] ? ptr_inc(r_wr_ptr[w]) : r_wr_ptr[w];
            end
        end
    end

    // Entry storage carries no reset: contents are only observed behind ib_valid_o.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NumWarps; w++) begin
            if (w_write[w]) begin
                r_pc[w][r_wr_ptr[w]]   <= ib.dec_pc_i;
                r_mask[w][r_wr_ptr[w]] <= ib.dec_act_mask_i;
                r_inst[w][r_wr_ptr[w]] <= ib.dec_inst_i;
            end
        end
    end

    // Head view is read straight from storage; a fresh write shows up one cycle later.
    always_comb begin
        ib.ib_space_available_o = w_space;
        ib.ib_valid_o           = w_used_nz;
        ib.ib_pc_o              = {(NumWarps*PcWidth){1'b0}};
        ib.ib_act_mask_o        = {(NumWarps*WarpWidth){1'b0}};
        ib.ib_inst_o            = {(NumWarps*InstWidth){1'b0}};
        for (int w = 0; w < NumWarps; w++) begin
            ib.ib_pc_o[w*PcWidth +: PcWidth]           = r_pc[w][r_rd_ptr[w]];
            ib.ib_act_mask_o[w*WarpWidth +: WarpWidth] = r_mask[w][r_rd_ptr[w]];
            ib.ib_inst_o[w*InstWidth +: InstWidth]     = r_inst[w][r_rd_ptr[w]];
        end
    end

    instruction_buffer_chk #(
        .NumWarps (NumWarps),
        .WidW     (WidW)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fe_handshake_i (ib.fe_handshake_i),
        .fe_warp_id_i   (ib.fe_warp_id_i),
        .dec_valid_i    (ib.dec_valid_i),
        .dec_warp_id_i  (ib.dec_warp_id_i),
        .disp_pop_i     (ib.disp_pop_i),
        .space_i        (w_space),
        .resv_nz_i      (w_resv_nz),
        .used_nz_i      (w_used_nz),
        .over_i         (w_over)
    );
endmodule
